// File: rtl/jk_pkg.sv
// Shared types and the per-bit next-state rule for the JK register bank.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE = 2'b00,
        SR_MODE = 2'b01,
        T_MODE  = 2'b10,
        D_MODE  = 2'b11
    } jk_mode_t;

    // Returns {q_next, illegal}; illegal only for S=R=1 in SR mode, where the bit holds.
    function automatic logic [1:0] jk_next(jk_mode_t mode, logic j, logic k, logic q);
        logic q_nxt;
        logic ill;
        q_nxt = q;
        ill   = 1'b0;
        case (mode)
            JK_MODE: begin
                case ({j, k})
                    2'b00:   q_nxt = q;
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    default: q_nxt = ~q;
                endcase
            end
            SR_MODE: begin
                case ({j, k})
                    2'b00:   q_nxt = q;
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    default: begin
                        q_nxt = q;
                        ill   = 1'b1;
                    end
                endcase
            end
            T_MODE:  q_nxt = j ? ~q : q;
            default: q_nxt = j;
        endcase
        return {q_nxt, ill};
    endfunction

endpackage

// File: rtl/jk_ff_bank_if.sv
// Control/data bundle for jk_ff_bank; master drives controls, slave returns state.
interface jk_ff_bank_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    jk_mode_t         mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clr_cnt;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] changed;
    logic [CNT_W-1:0] chg_cnt;
    logic             sr_err;

    // No handshake: every control is level-qualified at each rising clock edge.
    modport master (
        output en, mode, j, k, load, d, clr_cnt, clr_err,
        input  q, q_n, changed, chg_cnt, sr_err
    );

    modport slave (
        input  en, mode, j, k, load, d, clr_cnt, clr_err,
        output q, q_n, changed, chg_cnt, sr_err
    );
endinterface

// File: rtl/jk_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module jk_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH mode-selectable JK cells with parallel load, change flags,
// saturating change-event counter and sticky SR-illegal flag.
module jk_ff_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input logic         clk,
    input logic         rst,
    jk_ff_bank_if.slave bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] changed_q;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] cell_ill;
    logic             sr_ill;
    logic             any_chg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [1:0] nxt;
        assign nxt         = jk_next(bus.mode, bus.j[i], bus.k[i], q_q[i]);
        assign cell_d[i]   = nxt[1];
        assign cell_ill[i] = nxt[0];
    end

    // load overrides en; illegal SR only counts when the cells are actually updating.
    always_comb begin
        q_d    = q_q;
        sr_ill = 1'b0;
        if (bus.load) begin
            q_d = bus.d;
        end else if (bus.en) begin
            q_d    = cell_d;
            sr_ill = |cell_ill;
        end
    end

    assign any_chg = |(q_d ^ q_q);
    assign err_d   = sr_ill | (err_q & ~bus.clr_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            changed_q <= '0;
            err_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= q_d ^ q_q;
            err_q     <= err_d;
        end
    end

    jk_sat_counter #(
        .CNT_W(CNT_W)
    ) u_chg_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc_i(any_chg),
        .clr_i(bus.clr_cnt),
        .cnt_o(bus.chg_cnt)
    );

    assign bus.q       = q_q;
    assign bus.q_n     = ~q_q;
    assign bus.changed = changed_q;
    assign bus.sr_err  = err_q;
endmodule

// File: doc/jk_ff_bank.md
# jk_ff_bank

Parametrised multi-bit JK register bank: WIDTH independent JK cells sharing one clock, with runtime-selectable cell mode (JK/SR/T/D), synchronous parallel load, clock enable, per-bit change flags, a saturating change-event counter and a sticky SR-illegal flag. Drop-in state-holding primitive for control registers and small counters in the flip-flop library; supersedes single-bit JK instances where banks of them were hand-replicated.

## Interface
- WIDTH, 8, number of cells (≥1)
- RESET_VAL, '0, WIDTH-bit value loaded into q on reset
- CNT_W, 8, width of change-event counter (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable for mode update; ignored when load=1
- mode  in  2  cell mode: 00 JK, 01 SR, 10 T, 11 D (applies to all bits)
- j  in  WIDTH  J / S / T / D input per bit (by mode)
- k  in  WIDTH  K / R input per bit; ignored in T and D modes
- load  in  1  synchronous parallel load of d
- d  in  WIDTH  parallel load data
- clr_cnt  in  1  synchronous clear of change counter
- clr_err  in  1  synchronous clear of sr_err
- q  out  WIDTH  cell state
- q_n  out  WIDTH  ~q (combinational invert of q, never independently registered)
- changed  out  WIDTH  registered q_next ^ q of the last edge
- chg_cnt  out  CNT_W  saturating count of edges where any bit changed
- sr_err  out  1  sticky: SR mode saw S=R=1 on some bit while enabled

## Operation
- Reset (async assert, any time): q=RESET_VAL, q_n=~RESET_VAL, changed=0, chg_cnt=0, sr_err=0. Takes effect immediately, overrides every input; deassertion is synchronous to clk by the integrator.
- Next-state priority per edge: load > en > hold.
  - load=1: q_next=d regardless of en/mode.
  - en=0, load=0: q_next=q.
  - en=1, load=0, per bit i by mode:
    - JK: 00 hold, 01 clear, 10 set, 11 toggle.
    - SR: 00 hold, 01 clear, 10 set, 11 illegal → bit holds, sr_err set.
    - T: j[i]=1 toggle, 0 hold.
    - D: q_next[i]=j[i].
- changed <= q_next ^ q every edge (also during load and hold; hold yields 0).
- chg_cnt: increments by 1 on an edge where |(q_next ^ q); saturates at 2^CNT_W−1 (no wrap). clr_cnt=1 → chg_cnt=0 that edge; clear beats simultaneous increment.
- sr_err: set on illegal SR condition (any bit); clr_err clears; simultaneous set and clear → stays 1 (new event not lost). Illegal condition during load=1 or en=0 does not set it.
- mode may change on any cycle; new mode applies at the next edge, no pipeline.

## Timing
- Single-cycle latency: inputs sampled at rising clk, q/changed/chg_cnt/sr_err valid after that edge.
- All outputs except q_n are flops; q_n is ~q, no extra delay.
- No handshake; en/load are level-qualified per edge.
- Reset mid-operation: all state returns to reset values asynchronously; first post-reset edge evaluates normally from RESET_VAL (changed reflects difference from RESET_VAL).

## Structure
- Shared package jk_pkg: enum typedef jk_mode_t {JK_MODE=2'b00, SR_MODE=2'b01, T_MODE=2'b10, D_MODE=2'b11}; per-bit next-state function jk_next(mode,j,k,q) returning {q_next, illegal}.
- Sub-module jk_sat_counter (CNT_W, inc, clr, async rst, saturation) instantiated once for chg_cnt; cell array is a generate loop in the top.

## Test plan
- Reset with RESET_VAL=8'hA5 mid-clock-high → q=A5, q_n=5A, changed=00, chg_cnt=0, sr_err=0 immediately, before next edge.
- JK mode, q=00, en=1, j=F0, k=0F → q=F0; then j=k=FF → q=0F, changed=FF, chg_cnt=2.
- SR mode, q=0F, j=81, k=81 → q=0F unchanged, changed=00, sr_err=1; next edge clr_err=1 with j=k=01 → sr_err stays 1; then clr_err=1, j=k=00 → sr_err=0.
- load=1, en=0, d=3C, mode=T, j=FF → q=3C (load wins); en=0, load=0, j=FF → q holds, changed=00, chg_cnt unchanged.
- CNT_W=2, T mode j=01 for 5 edges → chg_cnt 1,2,3,3,3; clr_cnt=1 on 6th edge with toggle → chg_cnt=0.
